// File: rtl/fu_pkg.sv
// Shared definitions for integer execute units: default widths, opcode field
// position and the opcode encodings decoded by alu_core.
package fu_pkg;

    localparam int FU_DATA_W    = 16;
    localparam int FU_ROB_IDX_W = 4;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_ADD  = 4'd0;
    localparam opcode_t OP_SUB  = 4'd1;
    localparam opcode_t OP_AND  = 4'd2;
    localparam opcode_t OP_OR   = 4'd3;
    localparam opcode_t OP_XOR  = 4'd4;
    localparam opcode_t OP_SLL  = 4'd5;
    localparam opcode_t OP_SRL  = 4'd6;
    localparam opcode_t OP_SRA  = 4'd7;
    localparam opcode_t OP_SLT  = 4'd8;
    localparam opcode_t OP_SLTU = 4'd9;

    function automatic opcode_t get_opcode(input logic [15:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/alu_functional_unit_if.sv
// Dispatch, flush and CDB signals between the reservation station side
// (master) and the execute unit (slave).
interface alu_functional_unit_if
    import fu_pkg::*;
#(
    parameter int DATA_W    = FU_DATA_W,
    parameter int ROB_IDX_W = FU_ROB_IDX_W
);
    logic                 in_valid;
    logic [ROB_IDX_W-1:0] in_instr_index;
    logic [15:0]          in_instr_full;
    logic [DATA_W-1:0]    in_val1;
    logic [DATA_W-1:0]    in_val2;
    logic                 flush;
    logic                 cdb_grant;
    logic                 busy;
    logic                 cdb_valid;
    logic [ROB_IDX_W-1:0] cdb_rob_index;
    logic [DATA_W-1:0]    cdb_result;
    logic                 overflow_err;

    modport master (
        output in_valid, in_instr_index, in_instr_full, in_val1, in_val2,
        output flush, cdb_grant,
        input  busy, cdb_valid, cdb_rob_index, cdb_result, overflow_err
    );

    modport slave (
        input  in_valid, in_instr_index, in_instr_full, in_val1, in_val2,
        input  flush, cdb_grant,
        output busy, cdb_valid, cdb_rob_index, cdb_result, overflow_err
    );
endinterface

// File: rtl/alu_core.sv
// Combinational integer ALU; shift amounts come from b[3:0] and compares
// return 1/0. Undefined opcodes produce zero.
module alu_core
    import fu_pkg::*;
#(
    parameter int DATA_W = FU_DATA_W
) (
    input  opcode_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);
    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic [3:0]               shamt;

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[3:0];

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = a_s >>> shamt;
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/alu_functional_unit.sv
// Integer execute unit: skid queue (p0) -> registered EX operands (p1) ->
// writeback register (p2) that holds one CDB slot until granted.
module alu_functional_unit
    import fu_pkg::*;
#(
    parameter int DATA_W    = FU_DATA_W,
    parameter int ROB_IDX_W = FU_ROB_IDX_W,
    parameter int Q_DEPTH   = 2
) (
    input logic                   clk,
    input logic                   rst,
    alu_functional_unit_if.slave  fu
);
    localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int CNT_W = $clog2(Q_DEPTH + 1);

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(Q_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Stage p0: skid queue
    opcode_t              q_op_p0  [Q_DEPTH];
    logic [DATA_W-1:0]    q_a_p0   [Q_DEPTH];
    logic [DATA_W-1:0]    q_b_p0   [Q_DEPTH];
    logic [ROB_IDX_W-1:0] q_idx_p0 [Q_DEPTH];
    logic [CNT_W-1:0]     q_count_q, q_count_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic                 ovf_q, ovf_d;

    // Stage p1: EX operands
    logic                 vld_p1_q, vld_p1_d;
    opcode_t              op_p1_q;
    logic [DATA_W-1:0]    a_p1_q, b_p1_q;
    logic [ROB_IDX_W-1:0] idx_p1_q;

    // Stage p2: writeback / CDB slot
    logic                 vld_p2_q, vld_p2_d;
    logic [DATA_W-1:0]    res_p2_q;
    logic [ROB_IDX_W-1:0] idx_p2_q;

    logic [DATA_W-1:0]    alu_res;
    logic                 q_full, q_empty;
    logic                 wb_accept, ex_to_wb, ex_accept;
    logic                 pop, push_req, push, drop;
    logic                 unused_instr_bits;

    assign unused_instr_bits = ^fu.in_instr_full[OPC_LSB-1:0];

    assign q_full    = (q_count_q == CNT_W'(Q_DEPTH));
    assign q_empty   = (q_count_q == '0);
    assign wb_accept = !vld_p2_q || fu.cdb_grant;
    assign ex_to_wb  = vld_p1_q && wb_accept;
    assign ex_accept = !vld_p1_q || ex_to_wb;
    assign pop       = !q_empty && ex_accept;
    assign push_req  = fu.in_valid && !fu.flush;
    assign push      = push_req && (!q_full || pop);
    assign drop      = push_req && q_full && !pop;

    // Counts the issue already registered in the station this cycle.
    assign fu.busy = (int'(q_count_q) + int'(fu.in_valid)) >= Q_DEPTH;

    always_comb begin
        q_count_d = q_count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        vld_p1_d  = vld_p1_q;
        vld_p2_d  = vld_p2_q;
        ovf_d     = ovf_q | drop;
        if (fu.flush) begin
            q_count_d = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            vld_p1_d  = 1'b0;
            vld_p2_d  = 1'b0;
        end else begin
            if (push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            case ({push, pop})
                2'b10:   q_count_d = q_count_q + 1'b1;
                2'b01:   q_count_d = q_count_q - 1'b1;
                default: q_count_d = q_count_q;
            endcase
            if (ex_accept) vld_p1_d = pop;
            if (wb_accept) vld_p2_d = ex_to_wb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_count_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
        end else begin
            q_count_q <= q_count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            ovf_q     <= ovf_d;
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_op_p0[wr_ptr_q]  <= get_opcode(fu.in_instr_full);
            q_a_p0[wr_ptr_q]   <= fu.in_val1;
            q_b_p0[wr_ptr_q]   <= fu.in_val2;
            q_idx_p0[wr_ptr_q] <= fu.in_instr_index;
        end
        if (pop) begin
            op_p1_q  <= q_op_p0[rd_ptr_q];
            a_p1_q   <= q_a_p0[rd_ptr_q];
            b_p1_q   <= q_b_p0[rd_ptr_q];
            idx_p1_q <= q_idx_p0[rd_ptr_q];
        end
    end

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .op     (op_p1_q),
        .a      (a_p1_q),
        .b      (b_p1_q),
        .result (alu_res)
    );

    // WB data also resets so the CDB bus reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_p2_q <= '0;
            idx_p2_q <= '0;
        end else if (ex_to_wb) begin
            res_p2_q <= alu_res;
            idx_p2_q <= idx_p1_q;
        end
    end

    assign fu.cdb_valid     = vld_p2_q;
    assign fu.cdb_rob_index = idx_p2_q;
    assign fu.cdb_result    = res_p2_q;
    assign fu.overflow_err  = ovf_q;
endmodule

// File: tb/tb_alu_functional_unit.sv
// Directed bench for alu_functional_unit: latency, opcodes, stall/drain order,
// overflow, flush and asynchronous reset, with hand-computed expectations.
module tb_alu_functional_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_functional_unit_if #(.DATA_W(16), .ROB_IDX_W(4)) bus ();

    alu_functional_unit #(.DATA_W(16), .ROB_IDX_W(4), .Q_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .fu  (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] idx,
                         input logic [15:0] a, input logic [15:0] b);
        bus.in_valid       = 1'b1;
        bus.in_instr_index = idx;
        bus.in_instr_full  = {op, 12'hABC};
        bus.in_val1        = a;
        bus.in_val2        = b;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [3:0] op, input logic [3:0] idx,
                           input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
        drive(op, idx, a, b);
        step();
        idle();
        step();
        step();
        check({tag, "_valid"}, 32'(bus.cdb_valid), 32'd1);
        check({tag, "_result"}, 32'(bus.cdb_result), 32'(exp));
        check({tag, "_index"}, 32'(bus.cdb_rob_index), 32'(idx));
        step();
    endtask

    initial begin
        bus.in_valid       = 1'b0;
        bus.in_instr_index = '0;
        bus.in_instr_full  = '0;
        bus.in_val1        = '0;
        bus.in_val2        = '0;
        bus.flush          = 1'b0;
        bus.cdb_grant      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
        check("rst_cdb_index", 32'(bus.cdb_rob_index), 32'd0);
        check("rst_cdb_result", 32'(bus.cdb_result), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_overflow", 32'(bus.overflow_err), 32'd0);
        rst = 1'b0;
        step();

        // Latency: captured at edge 1, on CDB after edge 3 for one cycle.
        bus.cdb_grant = 1'b1;
        drive(4'd0, 4'd5, 16'h7FFF, 16'h0001);
        check("add_busy_issue", 32'(bus.busy), 32'd0);
        step();
        idle();
        check("add_lat_e1", 32'(bus.cdb_valid), 32'd0);
        step();
        check("add_lat_e2", 32'(bus.cdb_valid), 32'd0);
        step();
        check("add_valid", 32'(bus.cdb_valid), 32'd1);
        check("add_result", 32'(bus.cdb_result), 32'h8000);
        check("add_index", 32'(bus.cdb_rob_index), 32'd5);
        step();
        check("add_one_cycle", 32'(bus.cdb_valid), 32'd0);

        run_one("sub",  4'd1,  4'd1, 16'h0000, 16'h0001, 16'hFFFF);
        run_one("and",  4'd2,  4'd2, 16'hF0F0, 16'h3C3C, 16'h3030);
        run_one("or",   4'd3,  4'd3, 16'hF0F0, 16'h0F01, 16'hFFF1);
        run_one("xor",  4'd4,  4'd4, 16'hAAAA, 16'hFFFF, 16'h5555);
        run_one("sll",  4'd5,  4'd6, 16'h0001, 16'h0013, 16'h0008);
        run_one("srl",  4'd6,  4'd7, 16'h8000, 16'h0004, 16'h0800);
        run_one("sra",  4'd7,  4'd8, 16'h8000, 16'h0004, 16'hF800);
        run_one("slt",  4'd8,  4'd9, 16'hFFFF, 16'h0001, 16'h0001);
        run_one("sltu", 4'd9,  4'd10, 16'hFFFF, 16'h0001, 16'h0000);
        run_one("op12", 4'd12, 4'd11, 16'h1234, 16'h0001, 16'h0000);

        // Stall with grant low: four back-to-back issues fill WB, EX and queue.
        bus.cdb_grant = 1'b0;
        drive(4'd0, 4'd1, 16'h0010, 16'h0001);
        check("stall_busy_c0", 32'(bus.busy), 32'd0);
        step();
        drive(4'd0, 4'd2, 16'h0020, 16'h0002);
        check("stall_busy_c1", 32'(bus.busy), 32'd1);
        step();
        drive(4'd0, 4'd3, 16'h0030, 16'h0003);
        step();
        drive(4'd0, 4'd4, 16'h0040, 16'h0004);
        step();
        idle();
        check("stall_busy_full", 32'(bus.busy), 32'd1);
        check("stall_no_ovf", 32'(bus.overflow_err), 32'd0);
        check("stall_head_idx", 32'(bus.cdb_rob_index), 32'd1);
        step();
        step();
        check("stall_hold_valid", 32'(bus.cdb_valid), 32'd1);
        check("stall_hold_idx", 32'(bus.cdb_rob_index), 32'd1);
        check("stall_hold_res", 32'(bus.cdb_result), 32'h0011);

        // Forced issue into a full queue with no pop is dropped.
        drive(4'd0, 4'd5, 16'h0050, 16'h0005);
        step();
        idle();
        check("ovf_set", 32'(bus.overflow_err), 32'd1);

        bus.cdb_grant = 1'b1;
        check("drain_idx1", 32'(bus.cdb_rob_index), 32'd1);
        step();
        check("drain_v2", 32'(bus.cdb_valid), 32'd1);
        check("drain_idx2", 32'(bus.cdb_rob_index), 32'd2);
        check("drain_res2", 32'(bus.cdb_result), 32'h0022);
        step();
        check("drain_idx3", 32'(bus.cdb_rob_index), 32'd3);
        step();
        check("drain_idx4", 32'(bus.cdb_rob_index), 32'd4);
        check("drain_res4", 32'(bus.cdb_result), 32'h0044);
        step();
        check("drain_empty", 32'(bus.cdb_valid), 32'd0);
        step();
        check("drain_no_drop", 32'(bus.cdb_valid), 32'd0);
        check("ovf_sticky", 32'(bus.overflow_err), 32'd1);

        rst = 1'b1;
        #1;
        check("ovf_rst_clear", 32'(bus.overflow_err), 32'd0);
        rst = 1'b0;
        step();

        // Flush with WB, EX and queue all occupied, plus a same-cycle issue.
        bus.cdb_grant = 1'b0;
        drive(4'd0, 4'd6, 16'h0001, 16'h0001);
        step();
        drive(4'd0, 4'd7, 16'h0001, 16'h0001);
        step();
        drive(4'd0, 4'd8, 16'h0001, 16'h0001);
        step();
        drive(4'd0, 4'd9, 16'h0001, 16'h0001);
        step();
        drive(4'd0, 4'd10, 16'h0001, 16'h0001);
        bus.flush = 1'b1;
        check("flush_pre_valid", 32'(bus.cdb_valid), 32'd1);
        check("flush_pre_busy", 32'(bus.busy), 32'd1);
        step();
        bus.flush = 1'b0;
        idle();
        check("flush_valid", 32'(bus.cdb_valid), 32'd0);
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_no_ovf", 32'(bus.overflow_err), 32'd0);
        bus.cdb_grant = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("flush_quiet", 32'(bus.cdb_valid), 32'd0);
        end
        run_one("post_flush", 4'd0, 4'd11, 16'h0100, 16'h0023, 16'h0123);

        // Asynchronous reset between edges while WB holds a result.
        bus.cdb_grant = 1'b0;
        drive(4'd0, 4'd12, 16'h0002, 16'h0003);
        step();
        idle();
        step();
        step();
        check("arst_pre_valid", 32'(bus.cdb_valid), 32'd1);
        check("arst_pre_res", 32'(bus.cdb_result), 32'h0005);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.cdb_valid), 32'd0);
        check("arst_index", 32'(bus.cdb_rob_index), 32'd0);
        check("arst_result", 32'(bus.cdb_result), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        step();
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
